// File: rtl/gates_unit.sv
//------------------------------------------------------------------------------
// gates_unit
//   Handshaked, registered WIDTH-bit bitwise logic unit. Returns one selected
//   gate result per command, or all six two-input gate results (AND..XNOR) in
//   order when scan mode is requested.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module gates_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             scan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       y_op,
  output logic             busy,
  output logic [CNT_W-1:0] result_count
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_OUT     = 1'b1;
  localparam logic [2:0] C_OP_LAST = 3'd5;

  logic [0:0]       r_state;
  logic [0:0]       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_scan;
  logic [CNT_W-1:0] r_cnt;
  logic             r_live;
  logic             w_is_out;
  logic             w_last;
  logic             w_out_hs;
  logic             w_in_hs;
  logic [WIDTH-1:0] w_y;

  // Current result is the final one of its command (single, or scan at XNOR).
  assign w_is_out = (r_state == S_OUT);
  assign w_last   = !r_scan || (r_op == C_OP_LAST);
  assign w_out_hs = w_is_out && out_ready;
  assign w_in_hs  = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: a new command arriving with the last result keeps OUT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_hs) w_next = S_OUT;
      S_OUT:   if (w_out_hs && w_last && !w_in_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; in_ready is held low while in reset via r_live.
  always_comb begin
    out_valid = w_is_out;
    busy      = w_is_out;
    in_ready  = r_live && (!w_is_out || (out_ready && w_last));
  end

  // Goes high on the first edge after reset release, enabling in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Operand/command capture; scan steps op through 0..5 on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_scan <= 1'b0;
    end else if (w_in_hs) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= scan ? 3'd0 : op;
      r_scan <= scan;
    end else if (w_out_hs && !w_last) begin
      r_op   <= r_op + 3'd1;
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_cnt <= '0;
    else if (w_out_hs && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Gate function evaluated purely from registered operands.
  always_comb begin
    w_y = '0;
    case (r_op)
      3'd0:    w_y = r_a & r_b;
      3'd1:    w_y = ~(r_a & r_b);
      3'd2:    w_y = r_a | r_b;
      3'd3:    w_y = ~(r_a | r_b);
      3'd4:    w_y = r_a ^ r_b;
      3'd5:    w_y = ~(r_a ^ r_b);
      3'd6:    w_y = ~r_a;
      default: w_y = r_a;
    endcase
  end

  assign y            = w_y;
  assign y_op         = r_op;
  assign result_count = r_cnt;

endmodule

`default_nettype wire
